// File: rtl/upd7800_cpu_if.sv
// Bus bundle for the uPD7800 core: phase-enable strobes, address, data and M1.
// The CPU side is the master; the memory/board side is the slave.
interface upd7800_cpu_if;
   logic        cp1_posedge;
   logic        cp1_negedge;
   logic        cp2_posedge;
   logic        cp2_negedge;
   logic [15:0] a;
   logic [7:0]  db_i;
   logic [7:0]  db_o;
   logic        db_oe;
   logic        m1;

   modport master (
      input  cp1_posedge, cp1_negedge, cp2_posedge, cp2_negedge, db_i,
      output a, db_o, db_oe, m1
   );

   modport slave (
      output cp1_posedge, cp1_negedge, cp2_posedge, cp2_negedge, db_i,
      input  a, db_o, db_oe, m1
   );
endinterface

// File: rtl/upd7800_cpu.sv
// Reduced uPD7800 core: one machine cycle per CP1+/CP1-/CP2+/CP2- strobe group,
// with data sampled and instructions advanced on CP2- only.
module upd7800_cpu (
   input  logic          clk,
   input  logic          rst,
   upd7800_cpu_if.master bus
);
   typedef enum logic [2:0] {S_FETCH, S_OPND1, S_OPND2, S_READ, S_WRITE} state_t;

   localparam logic [2:0] R_A = 3'd1;
   localparam logic [2:0] R_H = 3'd6;
   localparam logic [2:0] R_L = 3'd7;

   state_t          state, state_n;
   logic [15:0]     pc, pc_n, sp, sp_n, pc_inc, hl;
   logic [7:0][7:0] rf, rf_n;
   logic [7:0]      op, op_n, lo, lo_n;
   logic            in_cycle, in_cycle_n;
   logic            cp2, cp2_n;
   logic [15:0]     a_q, a_n;
   logic [7:0]      db_o_q, db_o_n;
   logic            db_oe_q, db_oe_n, m1_q, m1_n;

   assign bus.a     = a_q;
   assign bus.db_o  = db_o_q;
   assign bus.db_oe = db_oe_q;
   assign bus.m1    = m1_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_FETCH;
         pc       <= '0;
         sp       <= '0;
         rf       <= '0;
         op       <= '0;
         lo       <= '0;
         in_cycle <= 1'b0;
         cp2      <= 1'b0;
         a_q      <= '0;
         db_o_q   <= '0;
         db_oe_q  <= 1'b0;
         m1_q     <= 1'b0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         sp       <= sp_n;
         rf       <= rf_n;
         op       <= op_n;
         lo       <= lo_n;
         in_cycle <= in_cycle_n;
         cp2      <= cp2_n;
         a_q      <= a_n;
         db_o_q   <= db_o_n;
         db_oe_q  <= db_oe_n;
         m1_q     <= m1_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      sp_n       = sp;
      rf_n       = rf;
      op_n       = op;
      lo_n       = lo;
      in_cycle_n = in_cycle;
      cp2_n      = cp2;
      a_n        = a_q;
      db_o_n     = db_o_q;
      db_oe_n    = db_oe_q;
      m1_n       = m1_q;
      pc_inc     = pc + 16'd1;
      hl         = {rf[R_H], rf[R_L]};

      if (bus.cp1_posedge) begin
         in_cycle_n = 1'b1;
         a_n        = (state == S_READ || state == S_WRITE) ? hl : pc;
         m1_n       = (state == S_FETCH);
         db_oe_n    = 1'b0;
         if (state == S_WRITE)
            db_o_n = rf[R_A];
      end

      // Strobes seen before the first CP1+ after reset are not part of a cycle.
      if (in_cycle && bus.cp1_negedge && state == S_WRITE)
         db_oe_n = 1'b1;

      if (in_cycle && bus.cp2_posedge)
         cp2_n = 1'b1;

      if (in_cycle && bus.cp2_negedge) begin
         cp2_n      = 1'b0;
         in_cycle_n = 1'b0;
         state_n    = S_FETCH;
         case (state)
            S_FETCH: begin
               pc_n = pc_inc;
               op_n = bus.db_i;
               if (bus.db_i[7:6] == 2'b11)
                  pc_n = pc_inc + {{10{bus.db_i[5]}}, bus.db_i[5:0]};
               else if (bus.db_i == 8'h54 || bus.db_i[7:3] == 5'b01101 ||
                        (bus.db_i[7:6] == 2'b00 && bus.db_i[3:0] == 4'h4))
                  state_n = S_OPND1;
               else if (bus.db_i == 8'h2D)
                  state_n = S_READ;
               else if (bus.db_i == 8'h3D)
                  state_n = S_WRITE;
            end
            S_OPND1: begin
               pc_n = pc_inc;
               lo_n = bus.db_i;
               if (op[7:3] == 5'b01101)
                  rf_n[op[2:0]] = bus.db_i;
               else
                  state_n = S_OPND2;
            end
            S_OPND2: begin
               pc_n = pc_inc;
               if (op == 8'h54)
                  pc_n = {bus.db_i, lo};
               else if (op[5:4] == 2'b00)
                  sp_n = {bus.db_i, lo};
               else begin
                  rf_n[{op[5:4], 1'b0}] = bus.db_i;
                  rf_n[{op[5:4], 1'b1}] = lo;
               end
            end
            S_READ:  rf_n[R_A] = bus.db_i;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_upd7800_cpu.sv
// Bench for upd7800_cpu: instruction-level reference model producing the expected
// bus-cycle stream, a per-cycle compare process, and directed literal checks.
module tb_upd7800_cpu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   upd7800_cpu_if bus();
   upd7800_cpu dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [15:0] addr;
      logic        m1;
      logic        wr;
      logic [7:0]  data;
   } cyc_t;

   int          n_pass = 0;
   int          n_tot  = 0;
   logic [7:0]  mem [65536];
   cyc_t        expq [$];
   cyc_t        cur;
   logic [15:0] m_pc, m_sp;
   logic [7:0]  m_r [8];
   logic        started;
   logic [15:0] exp_a;
   logic [7:0]  exp_do;
   logic        exp_m1, exp_oe, exp_cp2;
   logic [15:0] log_a [$];
   logic        log_m1 [$];
   logic        log_oe [$];
   logic [7:0]  log_do [$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   function automatic cyc_t mk(input logic [15:0] ad, input logic m, input logic w, input logic [7:0] d);
      cyc_t c;
      c.addr = ad; c.m1 = m; c.wr = w; c.data = d;
      return c;
   endfunction

   // Executes one whole instruction and queues the bus cycles it must produce.
   task automatic model_step();
      logic [7:0]  opc, lo, hi;
      logic [15:0] hl;
      int          off;
      opc = mem[m_pc];
      expq.push_back(mk(m_pc, 1'b1, 1'b0, 8'h00));
      m_pc++;
      hl = {m_r[6], m_r[7]};
      if (opc == 8'h54 || opc == 8'h04 || opc == 8'h14 || opc == 8'h24 || opc == 8'h34) begin
         lo = mem[m_pc]; expq.push_back(mk(m_pc, 1'b0, 1'b0, 8'h00)); m_pc++;
         hi = mem[m_pc]; expq.push_back(mk(m_pc, 1'b0, 1'b0, 8'h00)); m_pc++;
         case (opc)
            8'h54:   m_pc = {hi, lo};
            8'h04:   m_sp = {hi, lo};
            8'h14:   begin m_r[2] = hi; m_r[3] = lo; end
            8'h24:   begin m_r[4] = hi; m_r[5] = lo; end
            default: begin m_r[6] = hi; m_r[7] = lo; end
         endcase
      end else if (opc >= 8'h68 && opc <= 8'h6F) begin
         expq.push_back(mk(m_pc, 1'b0, 1'b0, 8'h00));
         m_r[opc - 8'h68] = mem[m_pc];
         m_pc++;
      end else if (opc == 8'h2D) begin
         expq.push_back(mk(hl, 1'b0, 1'b0, 8'h00));
         m_r[1] = mem[hl];
      end else if (opc == 8'h3D) begin
         expq.push_back(mk(hl, 1'b0, 1'b1, m_r[1]));
         mem[hl] = m_r[1];
      end else if (opc >= 8'hC0) begin
         off = int'(opc) - 8'hC0;
         if (off >= 32) off -= 64;
         m_pc = m_pc + 16'(off);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rst) begin
         exp_a = '0; exp_do = '0; exp_m1 = 0; exp_oe = 0; exp_cp2 = 0;
         started = 0; expq.delete();
         m_pc = '0; m_sp = '0;
         for (int i = 0; i < 8; i++) m_r[i] = '0;
      end else begin
         if (bus.cp1_posedge) begin
            if (expq.size() == 0) model_step();
            cur = expq.pop_front();
            exp_a = cur.addr; exp_m1 = cur.m1; exp_oe = 0;
            if (cur.wr) exp_do = cur.data;
            started = 1;
            log_a.push_back(bus.a);
            log_m1.push_back(bus.m1);
         end
         if (started && bus.cp1_negedge && cur.wr) exp_oe = 1;
         if (started && bus.cp2_posedge) exp_cp2 = 1;
         if (started && bus.cp2_negedge) begin
            exp_cp2 = 0; started = 0;
            log_oe.push_back(bus.db_oe);
            log_do.push_back(bus.db_o);
         end
      end
      check("a",     32'(bus.a),     32'(exp_a));
      check("m1",    32'(bus.m1),    32'(exp_m1));
      check("db_oe", 32'(bus.db_oe), 32'(exp_oe));
      check("db_o",  32'(bus.db_o),  32'(exp_do));
      check("cp2",   32'(dut.cp2),   32'(exp_cp2));
   end

   task automatic tick(input logic [3:0] s);
      @(negedge clk);
      bus.cp1_posedge = s[3];
      bus.cp1_negedge = s[2];
      bus.cp2_posedge = s[1];
      bus.cp2_negedge = s[0];
      bus.db_i = s[0] ? mem[bus.a] : 8'($urandom);
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      bus.cp1_posedge = 0; bus.cp1_negedge = 0; bus.cp2_posedge = 0; bus.cp2_negedge = 0;
      rst = 1;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      rst = 0;
   endtask

   task automatic mcyc(input int n, input bit gaps);
      logic [3:0] s;
      for (int i = 0; i < n; i++)
         for (int k = 0; k < 4; k++) begin
            if (gaps && $urandom_range(0, 399) == 0) pulse_rst();
            s = 4'b1000 >> k;
            tick(s);
            if (gaps) repeat ($urandom_range(0, 2)) tick(4'b0000);
         end
      tick(4'b0000);
   endtask

   task automatic start_test();
      pulse_rst();
      log_a.delete(); log_m1.delete(); log_oe.delete(); log_do.delete();
   endtask

   task automatic chk_cyc(input string nm, input int i, input logic [15:0] ea, input logic em1);
      check({nm, ".a"},  (i < log_a.size())  ? 32'(log_a[i])  : 32'hFFFF_FFFF, 32'(ea));
      check({nm, ".m1"}, (i < log_m1.size()) ? 32'(log_m1[i]) : 32'hFFFF_FFFF, 32'(em1));
   endtask

   task automatic chk_wr(input string nm, input int i, input logic eoe, input logic [7:0] ed);
      check({nm, ".oe"}, (i < log_oe.size()) ? 32'(log_oe[i]) : 32'hFFFF_FFFF, 32'(eoe));
      check({nm, ".do"}, (i < log_do.size()) ? 32'(log_do[i]) : 32'hFFFF_FFFF, 32'(ed));
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
   endtask

   task automatic chk_reset_vals(input string nm);
      #1;
      check({nm, ".a"},  32'(bus.a),     32'h0);
      check({nm, ".m1"}, 32'(bus.m1),    32'h0);
      check({nm, ".oe"}, 32'(bus.db_oe), 32'h0);
      check({nm, ".do"}, 32'(bus.db_o),  32'h0);
   endtask

   initial begin
      bus.cp1_posedge = 0; bus.cp1_negedge = 0; bus.cp2_posedge = 0; bus.cp2_negedge = 0;
      bus.db_i = 8'h00;
      clear_mem();
      repeat (2) @(negedge clk);
      chk_reset_vals("rst0");
      rst = 0;

      // All-zero memory: NOPs at consecutive addresses.
      start_test();
      mcyc(4, 0);
      for (int i = 0; i < 4; i++) chk_cyc("nop", i, 16'(i), 1'b1);

      // JMP 0x0123.
      clear_mem();
      mem[0] = 8'h54; mem[1] = 8'h23; mem[2] = 8'h01;
      start_test();
      mcyc(4, 0);
      chk_cyc("jmp0", 0, 16'h0000, 1'b1);
      chk_cyc("jmp1", 1, 16'h0001, 1'b0);
      chk_cyc("jmp2", 2, 16'h0002, 1'b0);
      chk_cyc("jmp3", 3, 16'h0123, 1'b1);

      // LXI HL,8000 / MVI A,5A / STAX.
      clear_mem();
      mem[0] = 8'h34; mem[1] = 8'h00; mem[2] = 8'h80; mem[3] = 8'h69; mem[4] = 8'h5A; mem[5] = 8'h3D;
      start_test();
      mcyc(8, 0);
      chk_cyc("stax", 6, 16'h8000, 1'b0);
      chk_wr("stax", 6, 1'b1, 8'h5A);
      chk_wr("stax_prev", 5, 1'b0, 8'h00);

      // LXI HL,0010 / LDAX / STAX.
      clear_mem();
      mem[0] = 8'h34; mem[1] = 8'h10; mem[2] = 8'h00; mem[3] = 8'h2D; mem[4] = 8'h3D; mem[16'h10] = 8'hA7;
      start_test();
      mcyc(8, 0);
      chk_cyc("ldax", 4, 16'h0010, 1'b0);
      chk_cyc("ldax_next", 5, 16'h0004, 1'b1);
      chk_cyc("stax2", 6, 16'h0010, 1'b0);
      chk_wr("stax2", 6, 1'b1, 8'hA7);

      // JR -1 at 0x0005 loops on itself.
      clear_mem();
      mem[5] = 8'hFF;
      start_test();
      mcyc(9, 1);
      for (int i = 5; i < 9; i++) chk_cyc("jr", i, 16'h0005, 1'b1);

      // Reset during the hi-operand read of a JMP.
      clear_mem();
      mem[0] = 8'h54; mem[1] = 8'h23; mem[2] = 8'h01;
      start_test();
      mcyc(2, 0);
      tick(4'b1000);
      tick(4'b0100);
      @(negedge clk);
      bus.cp1_posedge = 0; bus.cp1_negedge = 0;
      rst = 1;
      chk_reset_vals("midrst");
      @(negedge clk);
      rst = 0;
      tick(4'b0010);
      tick(4'b0001);
      tick(4'b0000);
      log_a.delete(); log_m1.delete(); log_oe.delete(); log_do.delete();
      mcyc(3, 0);
      chk_cyc("midrst0", 0, 16'h0000, 1'b1);
      chk_cyc("midrst1", 1, 16'h0001, 1'b0);
      chk_cyc("midrst2", 2, 16'h0002, 1'b0);

      // Random programs with strobe gaps and occasional mid-cycle resets.
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
         for (int i = 0; i < 64; i++) mem[$urandom_range(0, 255)] = 8'h68 + 8'($urandom_range(0, 7));
         start_test();
         mcyc(600, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/upd7800_cpu.md
# upd7800_cpu

Reduced NEC uPD7800-compatible CPU core for the Super Cassette Vision system. It fetches and executes a defined instruction subset over a 16-bit address / 8-bit data bus. Bus activity is paced by four externally generated phase-enable strobes (CP1/CP2 rising and falling edges), all qualified by a single clock. At system level, the boot ROM sits in 0x0000–0x0FFF and is selected whenever A[15:12] = 0.

## Interface
- No parameters.
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset. The board-level active-low RESETB is inverted outside this block.
- CP1_POSEDGE  in  1  phase enable, one CLK wide; starts a machine cycle.
- CP1_NEGEDGE  in  1  phase enable; follows CP1_POSEDGE.
- CP2_POSEDGE  in  1  phase enable; follows CP1_NEGEDGE.
- CP2_NEGEDGE  in  1  phase enable; ends a machine cycle.
- A  out  16  address bus.
- DB_I  in  8  read data.
- DB_O  out  8  write data.
- DB_OE  out  1  DB_O drive enable.
- M1  out  1  high during opcode-fetch machine cycles.

## Operation
- Register set:
  - 8-bit registers V, A, B, C, D, E, H, L.
  - 16-bit PC and SP.
  - Internal net cp2: set on CP2_POSEDGE, cleared on CP2_NEGEDGE. It is kept as a probe point.
- Reset values: all registers 0, PC = 0x0000, A = 0x0000, DB_O = 0x00, DB_OE = 0, M1 = 0, cp2 = 0. The FSM goes to FETCH.
- Each memory access uses one machine cycle, one of three kinds:
  - FETCH: opcode read, M1 = 1.
  - OPERAND: immediate read.
  - READ / WRITE: data access.
- Every FETCH and OPERAND read uses address PC, and PC is incremented by 1 at the end of the cycle. PC wraps from 0xFFFF to 0x0000.
- Instruction subset (cycle count includes the fetch):
  - 0x00 NOP: 1 cycle.
  - 0x54 JMP lo,hi: 3 cycles; PC <= {hi,lo}.
  - 0x68–0x6F MVI r,imm: 2 cycles; r = V,A,B,C,D,E,H,L in opcode order.
  - 0x04 / 0x14 / 0x24 / 0x34 LXI SP/BC/DE/HL, lo,hi: 3 cycles. lo goes to the low register (C, E, L); hi goes to the high register (B, D, H).
  - 0x2D LDAX H: 2 cycles; READ at {H,L}; A <= data.
  - 0x3D STAX H: 2 cycles; WRITE A to {H,L}.
  - 0xC0–0xFF JR: 1 cycle. PC <= PC_next + sign-extended opcode[5:0], giving a range of −32..+31 relative to the next instruction.
  - Any other opcode: executes as NOP, 1 cycle.

## Timing
- The phase strobes arrive as CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE on consecutive CLK cycles, so one machine cycle = 4 CLK.
- Outputs change only on CLK edges where a strobe is high, except under RESET.
- On CP1_POSEDGE:
  - A <= cycle address.
  - M1 <= 1 for FETCH, 0 otherwise.
- DB_I is sampled on the CLK edge with CP2_NEGEDGE. Opcode and operand decode uses that sampled byte.
- WRITE cycle:
  - DB_O <= data at CP1_POSEDGE.
  - DB_OE = 1 from CP1_NEGEDGE until the next CP1_POSEDGE.
  - DB_OE is 0 in every other cycle.
- A and DB_O hold their values between cycles.
- The first cycle after RESET deasserts is a FETCH at 0x0000, beginning at the first CP1_POSEDGE. Strobes arriving mid-sequence before that CP1_POSEDGE are ignored.
- RESET asserted mid-instruction immediately forces the reset values. Any partially fetched operands are discarded.
- Strobes held low: the FSM freezes, with no state or output change.
- DB_I = X during non-ROM cycles must not corrupt state unless that cycle's data is actually used.

## Test plan
- Reset release, memory all 0x00: M1 = 1 and A = 0x0000 on the first CP1_POSEDGE; A increments by 1 every 4 CLK.
- 54 23 01 at 0x0000: three cycles at A = 0000, 0001, 0002 with M1 = 1, 0, 0; the next FETCH is at A = 0x0123.
- 34 00 80 69 5A 3D: a WRITE cycle at A = 0x8000 with DB_O = 0x5A, DB_OE = 1, M1 = 0; DB_OE = 0 in all other cycles.
- 34 10 00 2D at 0x0000, ROM[0x0010] = 0xA7, followed by 3D: a READ at 0x0010 returns A = 0xA7, then a WRITE at 0x0010 outputs DB_O = 0xA7.
- 0xFF at 0x0005: FETCH repeats at A = 0x0005 forever (JR −1).
- RESET pulsed during the hi-operand read of a JMP: outputs return to reset values, and the FETCH restarts at 0x0000 after release.
